id_scoreboard_ctrl: RTL and testbench
=====================================

Name: id_scoreboard_ctrl

Overview:
- Issue controller for the decode stage of the 5-stage ARM pipeline.
- Keeps a scoreboard of in-flight destination registers and in-flight flag writers.
- Raises `hazard` to freeze IF and ID, raises `flush` on a taken branch, and qualifies each issue into the ID/EXE register.
- Also keeps a stall-cycle performance counter and a sticky scoreboard-error flag.

Parameters:
- NREG, 16: architectural registers tracked (R0–R15).
- CNT_W, 2: width of the per-register pending counter. At most 3 writers are in flight (EXE, MEM, WB).
- WB_BYPASS, 1: when 1, a write-back retiring in the same cycle clears a hazard, because the register file writes in the first half-cycle.
- PERF_W, 32: width of the stall counter.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- src1  in  4  first source register of the ID instruction
- src2  in  4  second source register of the ID instruction
- Two_src  in  1  src2 is actually read
- id_wb_en  in  1  ID instruction writes Dest
- id_dest  in  4  destination of the ID instruction
- id_s  in  1  ID instruction updates SR
- id_uses_flags  in  1  condition is not AL, so SR is read
- exe_sr_update  in  1  an instruction in EXE writes SR this cycle
- writeBackEn  in  1  WB writes the register file
- Dest_wb  in  4  WB destination
- branch_taken  in  1  branch resolved taken in EXE
- hazard  out  1  stall IF, IF/ID and ID
- flush  out  1  kill IF/ID and ID/EXE contents
- issue  out  1  ID instruction enters ID/EXE this cycle
- pending_any  out  1  some counter is nonzero
- stall_count  out  PERF_W  cycles with hazard=1
- sb_error  out  1  sticky overflow/underflow flag

Behaviour:
- Reset (synchronous, rst=1 at posedge clk) sets:
  - every pend[r] = 0 and flag_pend = 0
  - stall_count = 0, sb_error = 0
  - hazard, flush, issue and pending_any evaluate to 0 after reset.
- Register hazard (combinational from registered state):
  - busy(r) = pend[r] != 0.
  - If WB_BYPASS=1, busy(r) is forced to 0 when pend[r]==1 and writeBackEn and Dest_wb==r.
  - rhaz = busy(src1) | (Two_src & busy(src2)).
- Flag hazard: fhaz = id_uses_flags & (flag_pend != 0). No bypass: SR updates at the clock edge.
- hazard = id_valid & (rhaz | fhaz) & ~branch_taken.
- flush = branch_taken, same cycle, no latency.
- issue = id_valid & ~hazard & ~branch_taken.
- Register scoreboard update at each posedge, for each register r:
  - inc = issue & id_wb_en & id_dest==r
  - dec = writeBackEn & Dest_wb==r
  - inc and dec both set: pend[r] unchanged.
  - inc only at max (3): pend[r] holds at 3 and sb_error is set.
  - dec only at 0: pend[r] holds at 0 and sb_error is set.
- Flag scoreboard update at each posedge:
  - flag_pend increments on issue & id_s.
  - flag_pend decrements on exe_sr_update.
  - Simultaneous increment and decrement: unchanged.
  - Same saturation and error rules as the register counters, width 2.
- stall_count increments on each cycle with hazard=1 and wraps at 2^PERF_W−1 → 0 without setting an error.
- sb_error is cleared only by rst.
- Flushed ID instruction: never counted as issued.
  - Instructions already in EXE/MEM/WB are older than the branch and still retire normally, so the scoreboard needs no squash.
- R15 is tracked like any other register. PC writes are handled by branch_taken/flush.
- rst asserted mid-operation drops all pending state in the same cycle. The pipeline registers are reset by the same rst.

Decomposition:
- Shared package `arm_pipe_pkg`:
  - REG_W=4, NREG=16
  - the pend counter type (CNT_W)
  - constant COND_AL=4'b1110, used by the decoder to derive id_uses_flags
- Sub-module `sb_counter`: one saturating up/down counter with an error output. Instantiated NREG+1 times (16 registers plus flags).

Test Plan:
- Reset, then issue MOV R1 (id_wb_en, id_dest=1). Next cycle ID reads src1=1 → hazard=1, issue=0. Then writeBackEn with Dest_wb=1 in the same cycle → with WB_BYPASS=1, hazard=0, issue=1, pend[1]=0.
- Issue 3 back-to-back writers of R2 with no retires → pend[2]=3. A 4th forced issue → pend[2] stays 3, sb_error=1 and persists until rst.
- Issue ADDS (id_s=1). Next instruction has id_uses_flags=1 → hazard=1 until the exe_sr_update cycle has passed; that cycle itself still stalls. Then issue=1 and flag_pend=0.
- While hazard=1 on R3, assert branch_taken → flush=1, hazard=0, issue=0. pend[3] is unaffected, and stall_count does not increment that cycle.
- In one cycle: issue a writer of R4 and retire R4 (pend[4]=1) → pend[4] stays 1. Retire R5 with pend[5]=0 → pend[5]=0, sb_error=1.
- 10 consecutive hazard cycles, then rst mid-stall → stall_count=10 before reset; all pend, stall_count and sb_error are 0 the cycle after reset.

Source files
------------

// File: rtl/arm_pipe_pkg.sv
// Shared definitions for the ARM pipeline decode/issue logic.
// Register-index width, scoreboard counter type and the "always" condition code.
package arm_pipe_pkg;
  localparam int REG_W = 4;
  localparam int NREG  = 16;
  localparam int CNT_W = 2;

  typedef logic [CNT_W-1:0] pend_t;

  // Condition field meaning "always"; anything else reads the status register.
  localparam logic [3:0] COND_AL = 4'b1110;

  function automatic logic cond_reads_flags(input logic [3:0] cond);
    return cond != COND_AL;
  endfunction
endpackage

// File: rtl/id_scoreboard_ctrl_if.sv
// Decode-stage issue bus: ID instruction fields and retire events in,
// hazard/flush/issue qualifiers and status out.
interface id_scoreboard_ctrl_if #(parameter int PERF_W = 32);
  import arm_pipe_pkg::*;

  logic              id_valid;
  logic [REG_W-1:0]  src1;
  logic [REG_W-1:0]  src2;
  logic              Two_src;
  logic              id_wb_en;
  logic [REG_W-1:0]  id_dest;
  logic              id_s;
  logic              id_uses_flags;
  logic              exe_sr_update;
  logic              writeBackEn;
  logic [REG_W-1:0]  Dest_wb;
  logic              branch_taken;
  logic              hazard;
  logic              flush;
  logic              issue;
  logic              pending_any;
  logic [PERF_W-1:0] stall_count;
  logic              sb_error;

  modport master (
    output id_valid, src1, src2, Two_src, id_wb_en, id_dest, id_s, id_uses_flags,
           exe_sr_update, writeBackEn, Dest_wb, branch_taken,
    input  hazard, flush, issue, pending_any, stall_count, sb_error
  );

  modport slave (
    input  id_valid, src1, src2, Two_src, id_wb_en, id_dest, id_s, id_uses_flags,
           exe_sr_update, writeBackEn, Dest_wb, branch_taken,
    output hazard, flush, issue, pending_any, stall_count, sb_error
  );
endinterface

// File: rtl/id_scoreboard_ctrl_sb_counter.sv
// Saturating up/down pending counter; o_err pulses when an update would
// overflow or underflow, and the count holds instead of wrapping.
module sb_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_inc,
  input  logic         i_dec,
  output logic [W-1:0] o_cnt,
  output logic         o_err
);
  localparam logic [W-1:0] MAX = '1;

  logic [W-1:0] r_cnt;
  logic         w_up;
  logic         w_dn;
  logic         w_ovf;
  logic         w_unf;

  always_comb begin
    w_up  = i_inc & ~i_dec;
    w_dn  = i_dec & ~i_inc;
    w_ovf = w_up & (r_cnt == MAX);
    w_unf = w_dn & (r_cnt == '0);
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_cnt <= '0;
    else if (w_up && !w_ovf)
      r_cnt <= r_cnt + W'(1);
    else if (w_dn && !w_unf)
      r_cnt <= r_cnt - W'(1);
  end

  assign o_cnt = r_cnt;
  assign o_err = w_ovf | w_unf;
endmodule

// File: rtl/id_scoreboard_ctrl.sv
// Decode-stage issue controller: register/flag scoreboard, stall and flush
// qualification, stall-cycle counter and sticky scoreboard error.
module id_scoreboard_ctrl #(
  parameter int NREG      = arm_pipe_pkg::NREG,
  parameter int CNT_W     = arm_pipe_pkg::CNT_W,
  parameter int WB_BYPASS = 1,
  parameter int PERF_W    = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  id_scoreboard_ctrl_if.slave   bus
);
  import arm_pipe_pkg::*;

  logic [CNT_W-1:0]  w_pend [NREG];
  logic [NREG-1:0]   w_inc;
  logic [NREG-1:0]   w_dec;
  logic [NREG-1:0]   w_busy;
  logic [NREG-1:0]   w_nz;
  logic [NREG-1:0]   w_reg_err;
  logic [CNT_W-1:0]  w_flag_pend;
  logic              w_flag_inc;
  logic              w_flag_err;
  logic              w_rhaz;
  logic              w_fhaz;
  logic              w_hazard;
  logic              w_issue;
  logic [PERF_W-1:0] r_stall_count;
  logic              r_sb_error;

  for (genvar g = 0; g < NREG; g++) begin : g_reg
    sb_counter #(.W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .i_inc (w_inc[g]),
      .i_dec (w_dec[g]),
      .o_cnt (w_pend[g]),
      .o_err (w_reg_err[g])
    );
  end

  sb_counter #(.W(CNT_W)) u_flag (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_flag_inc),
    .i_dec (bus.exe_sr_update),
    .o_cnt (w_flag_pend),
    .o_err (w_flag_err)
  );

  // The register file writes in the first half-cycle, so the last in-flight
  // writer retiring now no longer blocks a reader.
  always_comb begin
    w_dec  = '0;
    w_busy = '0;
    w_nz   = '0;
    for (int r = 0; r < NREG; r++) begin
      w_dec[r]  = bus.writeBackEn & (bus.Dest_wb == REG_W'(r));
      w_nz[r]   = (w_pend[r] != '0);
      w_busy[r] = w_nz[r] &
                  ~((WB_BYPASS != 0) & (w_pend[r] == CNT_W'(1)) & w_dec[r]);
    end
  end

  always_comb begin
    w_rhaz   = w_busy[bus.src1] | (bus.Two_src & w_busy[bus.src2]);
    w_fhaz   = bus.id_uses_flags & (w_flag_pend != '0);
    w_hazard = bus.id_valid & (w_rhaz | w_fhaz) & ~bus.branch_taken;
    w_issue  = bus.id_valid & ~w_hazard & ~bus.branch_taken;
  end

  always_comb begin
    w_inc = '0;
    for (int r = 0; r < NREG; r++)
      w_inc[r] = w_issue & bus.id_wb_en & (bus.id_dest == REG_W'(r));
    w_flag_inc = w_issue & bus.id_s;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_count <= '0;
      r_sb_error    <= 1'b0;
    end else begin
      if (w_hazard)
        r_stall_count <= r_stall_count + PERF_W'(1);
      if ((|w_reg_err) || w_flag_err)
        r_sb_error <= 1'b1;
    end
  end

  assign bus.hazard      = w_hazard;
  assign bus.flush       = bus.branch_taken;
  assign bus.issue       = w_issue;
  assign bus.pending_any = (|w_nz) | (w_flag_pend != '0);
  assign bus.stall_count = r_stall_count;
  assign bus.sb_error    = r_sb_error;
endmodule

// File: tb/tb_id_scoreboard_ctrl.sv
// Directed bench for id_scoreboard_ctrl: the driver queues hand-computed
// expected outputs per cycle, a monitor pops and compares them mid-cycle.
module tb_id_scoreboard_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;

  id_scoreboard_ctrl_if #(.PERF_W(32)) bus ();

  id_scoreboard_ctrl #(.WB_BYPASS(1), .PERF_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic        hz;
    logic        fl;
    logic        is;
    logic        pa;
    logic [31:0] sc;
    logic        err;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   vec    = 0;

  task automatic chk1(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic cyc(
    input logic r, input logic v, input logic [3:0] s1, input logic [3:0] s2,
    input logic two, input logic wen, input logic [3:0] d, input logic s,
    input logic uf, input logic esr, input logic wbe, input logic [3:0] dwb,
    input logic br, input logic chk,
    input logic ehz, input logic efl, input logic eis, input logic epa,
    input int esc, input logic eerr);
    exp_t e;
    @(posedge clk);
    #1;
    rst               = r;
    bus.id_valid      = v;
    bus.src1          = s1;
    bus.src2          = s2;
    bus.Two_src       = two;
    bus.id_wb_en      = wen;
    bus.id_dest       = d;
    bus.id_s          = s;
    bus.id_uses_flags = uf;
    bus.exe_sr_update = esr;
    bus.writeBackEn   = wbe;
    bus.Dest_wb       = dwb;
    bus.branch_taken  = br;
    if (chk) begin
      e.idx = vec; e.hz = ehz; e.fl = efl; e.is = eis;
      e.pa = epa; e.sc = 32'(esc); e.err = eerr;
      q.push_back(e);
    end
    vec++;
  endtask

  task automatic idle(input logic epa, input int esc, input logic eerr);
    cyc(0,0,0,0,0,0,0,0,0,0,0,0,0, 1, 0,0,0,epa,esc,eerr);
  endtask

  // Monitor: outputs are combinational from state plus inputs, so sample mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk1("hazard",      e.idx, 32'(bus.hazard),      32'(e.hz));
        chk1("flush",       e.idx, 32'(bus.flush),       32'(e.fl));
        chk1("issue",       e.idx, 32'(bus.issue),       32'(e.is));
        chk1("pending_any", e.idx, 32'(bus.pending_any), 32'(e.pa));
        chk1("stall_count", e.idx, bus.stall_count,      e.sc);
        chk1("sb_error",    e.idx, 32'(bus.sb_error),    32'(e.err));
      end
    end
  end

  initial begin
    bus.id_valid = 0; bus.src1 = 0; bus.src2 = 0; bus.Two_src = 0;
    bus.id_wb_en = 0; bus.id_dest = 0; bus.id_s = 0; bus.id_uses_flags = 0;
    bus.exe_sr_update = 0; bus.writeBackEn = 0; bus.Dest_wb = 0; bus.branch_taken = 0;

    cyc(1,0,0,0,0,0,0,0,0,0,0,0,0, 0, 0,0,0,0,0,0);
    cyc(1,0,0,0,0,0,0,0,0,0,0,0,0, 0, 0,0,0,0,0,0);
    idle(0, 0, 0);

    // RAW on R1, then cleared by same-cycle write-back
    cyc(0,1,0,0,0,1,1,0,0,0,0,0,0, 1, 0,0,1,0,0,0);
    cyc(0,1,1,0,0,0,0,0,0,0,0,0,0, 1, 1,0,0,1,0,0);
    cyc(0,1,1,0,0,0,0,0,0,0,1,1,0, 1, 0,0,1,1,1,0);
    idle(0, 1, 0);

    // Three writers of R2 fill the counter; a fourth overflows
    for (int i = 0; i < 3; i++)
      cyc(0,1,0,0,0,1,2,0,0,0,0,0,0, 1, 0,0,1,(i > 0),1,0);
    cyc(0,1,0,0,0,1,2,0,0,0,0,0,0, 1, 0,0,1,1,1,0);
    idle(1, 1, 1);
    for (int i = 0; i < 3; i++)
      cyc(0,0,0,0,0,0,0,0,0,0,1,2,0, 1, 0,0,0,1,1,1);
    idle(0, 1, 1);

    // Flag hazard: the exe_sr_update cycle itself still stalls
    cyc(0,1,0,0,0,0,0,1,0,0,0,0,0, 1, 0,0,1,0,1,1);
    cyc(0,1,0,0,0,0,0,0,1,0,0,0,0, 1, 1,0,0,1,1,1);
    cyc(0,1,0,0,0,0,0,0,1,1,0,0,0, 1, 1,0,0,1,2,1);
    cyc(0,1,0,0,0,0,0,0,1,0,0,0,0, 1, 0,0,1,0,3,1);

    // Branch during an R3 stall: flush wins, no stall counted, R3 still pending
    cyc(0,1,0,0,0,1,3,0,0,0,0,0,0, 1, 0,0,1,0,3,1);
    cyc(0,1,3,0,0,0,0,0,0,0,0,0,0, 1, 1,0,0,1,3,1);
    cyc(0,1,3,0,0,0,0,0,0,0,0,0,1, 1, 0,1,0,1,4,1);
    cyc(0,1,3,0,0,0,0,0,0,0,0,0,0, 1, 1,0,0,1,4,1);
    cyc(0,1,0,3,0,0,0,0,0,0,0,0,0, 1, 0,0,1,1,5,1);
    cyc(0,1,0,3,1,0,0,0,0,0,0,0,0, 1, 1,0,0,1,5,1);
    cyc(0,0,0,0,0,0,0,0,0,0,1,3,0, 1, 0,0,0,1,6,1);

    // Simultaneous issue and retire of R4 leaves pend[4] at 1
    cyc(0,1,0,0,0,1,4,0,0,0,0,0,0, 1, 0,0,1,0,6,1);
    cyc(0,1,0,0,0,1,4,0,0,0,1,4,0, 1, 0,0,1,1,6,1);
    cyc(0,1,4,0,0,0,0,0,0,0,0,0,0, 1, 1,0,0,1,6,1);
    cyc(0,1,4,0,0,0,0,0,0,0,1,4,0, 1, 0,0,1,1,7,1);
    idle(0, 7, 1);

    // Underflow on R5 from a clean reset
    cyc(1,0,0,0,0,0,0,0,0,0,0,0,0, 0, 0,0,0,0,0,0);
    idle(0, 0, 0);
    cyc(0,0,0,0,0,0,0,0,0,0,1,5,0, 1, 0,0,0,0,0,0);
    idle(0, 0, 1);
    cyc(0,1,5,0,0,0,0,0,0,0,0,0,0, 1, 0,0,1,0,0,1);

    // Ten stall cycles on R6, then reset mid-stall
    cyc(0,1,0,0,0,1,6,0,0,0,0,0,0, 1, 0,0,1,0,0,1);
    for (int i = 0; i < 10; i++)
      cyc(0,1,6,0,0,0,0,0,0,0,0,0,0, 1, 1,0,0,1,i,1);
    cyc(1,1,6,0,0,0,0,0,0,0,0,0,0, 1, 1,0,0,1,10,1);
    cyc(0,1,6,0,0,0,0,0,0,0,0,0,0, 1, 0,0,1,0,0,0);
    idle(0, 0, 0);

    for (int i = 0; i < 20 && q.size() > 0; i++)
      @(posedge clk);
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries never compared, required 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
